// File: rtl/ps2_key_event.sv
// ps2_key_event: turns the raw PS/2 scan-code byte stream from ps2_keyboard
// into discrete press/release events. Strips F0 (break) and E0 (extended)
// prefixes, suppresses typematic repeats of the held key, counts accepted
// presses and queues events in a first-word-fall-through FIFO.
//
// Build option: define PS2_KEY_EVENT_EXT_EN to build E0 (extended key)
// handling. Without it, E0 bytes are discarded wherever they appear and
// evt_ext / cur_ext are constant 0.
module ps2_key_event #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             code_valid,
  input  logic [7:0]       code_data,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_break,
  output logic             evt_ext,
  output logic             key_down,
  output logic [7:0]       cur_code,
  output logic             cur_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GOT_F0   = 2'd1
`ifdef PS2_KEY_EVENT_EXT_EN
    ,
    S_GOT_E0   = 2'd2,
    S_GOT_E0F0 = 2'd3
`endif
  } state_t;

`ifdef PS2_KEY_EVENT_EXT_EN
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;
`else
  typedef struct packed {
    logic       brk;
    logic [7:0] code;
  } evt_t;
`endif

  // Keyboard housekeeping bytes (error, BAT ok, ack, error) that never
  // start or complete a key event when seen outside a prefix.
  function automatic logic is_filler(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFF);
  endfunction

  state_t           state_q, state_d;
  logic             key_down_q, key_down_d;
  logic [7:0]       cur_code_q, cur_code_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic             overflow_q, overflow_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  evt_t             mem_q [FIFO_DEPTH];
  evt_t             mem_d [FIFO_DEPTH];
`ifdef PS2_KEY_EVENT_EXT_EN
  logic             cur_ext_q, cur_ext_d;
  logic             ev_ext;
`endif

  // Decoded event for this cycle (valid only when ev_fire is high).
  logic       ev_fire;
  logic       ev_brk;
  logic [7:0] ev_code;

  // Key-tracking and FIFO control terms.
  logic is_make;
  logic is_brk;
  logic held_match;
  logic push;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic wr_en;
  logic drop;
  evt_t head;
  evt_t new_evt;

  // Prefix FSM: next state and the completed event, advanced only on code_valid.
  always_comb begin
    state_d = state_q;
    ev_fire = 1'b0;
    ev_brk  = 1'b0;
    ev_code = code_data;
`ifdef PS2_KEY_EVENT_EXT_EN
    ev_ext  = 1'b0;
`endif
    if (code_valid) begin
      case (state_q)
        S_IDLE: begin
          if (code_data == BYTE_E0) begin
`ifdef PS2_KEY_EVENT_EXT_EN
            state_d = S_GOT_E0;
`endif
          end else if (code_data == BYTE_F0) begin
            state_d = S_GOT_F0;
          end else if (!is_filler(code_data)) begin
            ev_fire = 1'b1;
          end
        end
        S_GOT_F0: begin
          if (code_data == BYTE_F0) begin
            state_d = S_GOT_F0;
`ifndef PS2_KEY_EVENT_EXT_EN
          end else if (code_data == BYTE_E0) begin
            state_d = S_GOT_F0;
`endif
          end else begin
            ev_fire = 1'b1;
            ev_brk  = 1'b1;
            state_d = S_IDLE;
          end
        end
`ifdef PS2_KEY_EVENT_EXT_EN
        S_GOT_E0: begin
          if (code_data == BYTE_F0) begin
            state_d = S_GOT_E0F0;
          end else if (code_data == BYTE_E0) begin
            state_d = S_GOT_E0;
          end else begin
            ev_fire = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_GOT_E0F0: begin
          if (code_data == BYTE_F0) begin
            state_d = S_GOT_E0F0;
          end else begin
            ev_fire = 1'b1;
            ev_brk  = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Held-key tracking: repeat suppression, press counting, release matching.
  always_comb begin
    is_make    = ev_fire && !ev_brk;
    is_brk     = ev_fire && ev_brk;
`ifdef PS2_KEY_EVENT_EXT_EN
    held_match = key_down_q && (ev_code == cur_code_q) && (ev_ext == cur_ext_q);
    cur_ext_d  = cur_ext_q;
`else
    held_match = key_down_q && (ev_code == cur_code_q);
`endif
    // A make of the already-held key is a typematic repeat and vanishes.
    push          = ev_fire && !(is_make && held_match);
    key_down_d    = key_down_q;
    cur_code_d    = cur_code_q;
    press_count_d = press_count_q;
    if (is_make && !held_match) begin
      key_down_d    = 1'b1;
      cur_code_d    = ev_code;
      press_count_d = press_count_q + CNT_W'(1);
`ifdef PS2_KEY_EVENT_EXT_EN
      cur_ext_d     = ev_ext;
`endif
    end else if (is_brk && held_match) begin
      key_down_d = 1'b0;
      cur_code_d = 8'h00;
`ifdef PS2_KEY_EVENT_EXT_EN
      cur_ext_d  = 1'b0;
`endif
    end
  end

  // Event FIFO: pointer arithmetic, full/empty, drop detection and storage update.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !fifo_empty && evt_ready;
    // A pop in the same cycle frees the slot the push needs.
    wr_en      = push && (!fifo_full || pop);
    drop       = push && fifo_full && !pop;
    wr_ptr_d   = wr_ptr_q + PW'(wr_en);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    overflow_d = overflow_q || drop;
    new_evt.brk  = ev_brk;
    new_evt.code = ev_code;
`ifdef PS2_KEY_EVENT_EXT_EN
    new_evt.ext  = ev_ext;
`endif
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = new_evt;
    end
  end

  // Control state: FSM, held key, counter, sticky overflow and FIFO pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      key_down_q    <= 1'b0;
      cur_code_q    <= 8'h00;
      press_count_q <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
`ifdef PS2_KEY_EVENT_EXT_EN
      cur_ext_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      key_down_q    <= key_down_d;
      cur_code_q    <= cur_code_d;
      press_count_q <= press_count_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
`ifdef PS2_KEY_EVENT_EXT_EN
      cur_ext_q     <= cur_ext_d;
`endif
    end
  end

  // Event storage needs no reset: entries are only visible behind a valid pointer pair.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Head of queue; fields read as zero while the FIFO is empty.
  always_comb begin
    head      = mem_q[rd_ptr_q[AW-1:0]];
    evt_valid = !fifo_empty;
    evt_code  = fifo_empty ? 8'h00 : head.code;
    evt_break = fifo_empty ? 1'b0  : head.brk;
`ifdef PS2_KEY_EVENT_EXT_EN
    evt_ext   = fifo_empty ? 1'b0  : head.ext;
    cur_ext   = cur_ext_q;
`else
    evt_ext   = 1'b0;
    cur_ext   = 1'b0;
`endif
  end

  assign key_down    = key_down_q;
  assign cur_code    = cur_code_q;
  assign press_count = press_count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Self-checking bench for ps2_key_event: directed scenarios plus randomized
// byte streams, compared every cycle against a behavioural event model.
module tb_ps2_key_event;

  localparam int DEPTH = 4;
  localparam int CW    = 8;
`ifdef PS2_KEY_EVENT_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          code_valid;
  logic [7:0]    code_data;
  logic          evt_valid;
  logic          evt_ready;
  logic [7:0]    evt_code;
  logic          evt_break;
  logic          evt_ext;
  logic          key_down;
  logic [7:0]    cur_code;
  logic          cur_ext;
  logic [CW-1:0] press_count;
  logic          overflow;

  ps2_key_event #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .code_valid (code_valid),
    .code_data  (code_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_break  (evt_break),
    .evt_ext    (evt_ext),
    .key_down   (key_down),
    .cur_code   (cur_code),
    .cur_ext    (cur_ext),
    .press_count(press_count),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: prefix flags, held key, count, sticky overflow, event queue.
  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ev_t;

  ev_t  q[$];
  bit   m_f0, m_e0;
  bit   m_held;
  byte  m_cur;
  bit   m_cur_ext;
  int   m_count;
  bit   m_ovf;

  task automatic model_reset();
    q.delete();
    m_f0 = 0; m_e0 = 0; m_held = 0; m_cur = 8'h00; m_cur_ext = 0;
    m_count = 0; m_ovf = 0;
  endtask

  // Apply one clock edge worth of behaviour given the inputs seen at that edge.
  task automatic model_edge(input bit cv, input byte b, input bit rdy, input bit rst);
    int  pre_size;
    bit  pop, have_ev, want_push;
    ev_t ev;
    if (rst) begin
      model_reset();
      return;
    end
    pre_size  = q.size();
    pop       = (pre_size > 0) && rdy;
    have_ev   = 0;
    want_push = 0;
    ev        = '0;
    if (cv) begin
      if (b == 8'hE0) begin
        if (EXT_EN) begin
          if (m_f0) begin
            have_ev = 1; ev.code = b; ev.brk = 1; ev.ext = m_e0;
          end else begin
            m_e0 = 1;
          end
        end
      end else if (b == 8'hF0) begin
        m_f0 = 1;
      end else if (!m_e0 && !m_f0 &&
                   (b == 8'h00 || b == 8'hAA || b == 8'hFA || b == 8'hFF)) begin
        // housekeeping byte, ignored
      end else begin
        have_ev = 1; ev.code = b; ev.brk = m_f0; ev.ext = m_e0;
      end
      if (have_ev) begin
        m_f0 = 0; m_e0 = 0;
      end
    end
    if (have_ev) begin
      if (!ev.brk) begin
        if (!(m_held && ev.code == m_cur && ev.ext == m_cur_ext)) begin
          want_push = 1;
          m_count   = (m_count + 1) % (1 << CW);
          m_held    = 1; m_cur = ev.code; m_cur_ext = ev.ext;
        end
      end else begin
        want_push = 1;
        if (m_held && ev.code == m_cur && ev.ext == m_cur_ext) begin
          m_held = 0; m_cur = 8'h00; m_cur_ext = 0;
        end
      end
    end
    if (pop) void'(q.pop_front());
    if (want_push) begin
      if (pre_size < DEPTH || pop) q.push_back(ev);
      else m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    bit ne;
    ne = (q.size() != 0);
    check("evt_valid",   32'(evt_valid),   32'(ne));
    check("evt_code",    32'(evt_code),    ne ? 32'(q[0].code) : 32'h0);
    check("evt_break",   32'(evt_break),   ne ? 32'(q[0].brk)  : 32'h0);
    check("evt_ext",     32'(evt_ext),     ne ? 32'(q[0].ext)  : 32'h0);
    check("key_down",    32'(key_down),    32'(m_held));
    check("cur_code",    32'(cur_code),    32'(m_cur));
    check("cur_ext",     32'(cur_ext),     32'(m_cur_ext));
    check("press_count", 32'(press_count), 32'(m_count));
    check("overflow",    32'(overflow),    32'(m_ovf));
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample 1 ns later.
  task automatic step(input bit cv, input byte b, input bit rdy, input bit rst);
    @(negedge clock);
    reset      = rst;
    code_valid = cv;
    code_data  = b;
    evt_ready  = rdy;
    @(posedge clock);
    model_edge(cv, b, rdy, rst);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 8'($urandom_range(0, 255)), rdy, 0);
  endtask

  task automatic send(input byte b, input bit rdy);
    step(1, b, rdy, 0);
    idle($urandom_range(0, 2), rdy);
  endtask

  task automatic do_reset();
    step(1, 8'h1C, 1, 1);
    step(0, 8'h00, 1, 1);
  endtask

  byte pool [10] = '{8'hE0, 8'hF0, 8'hF0, 8'h1C, 8'h1B, 8'h75, 8'h00, 8'hAA, 8'hFF, 8'h2C};

  initial begin
    reset = 1; code_valid = 0; code_data = 8'h00; evt_ready = 0;
    model_reset();
    do_reset();
    check("rst_evt_valid",   32'(evt_valid),   32'h0);
    check("rst_press_count", 32'(press_count), 32'h0);
    check("rst_cur_code",    32'(cur_code),    32'h0);

    // Press and release of one key.
    send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1); idle(3, 1);
    check("basic_count",  32'(press_count), 32'd1);
    check("basic_keydn",  32'(key_down),    32'd0);

    // Typematic repeats collapse to a single press.
    do_reset();
    send(8'h1B, 1); send(8'h1B, 1); send(8'h1B, 1); send(8'hF0, 1); send(8'h1B, 1);
    idle(3, 1);
    check("repeat_count", 32'(press_count), 32'd1);

    // Extended key press/release.
    do_reset();
    send(8'hE0, 0); send(8'h75, 0); send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    check("ext_head_code", 32'(evt_code), 32'h75);
    check("ext_head_ext",  32'(evt_ext),  32'(EXT_EN));
    idle(4, 1);

    // Overflow with consumer stalled, then drain in order.
    do_reset();
    send(8'h15, 0); send(8'h1D, 0); send(8'h24, 0); send(8'h2D, 0); send(8'h2C, 0);
    check("ovf_flag",  32'(overflow),    32'd1);
    check("ovf_count", 32'(press_count), 32'd5);
    check("ovf_head",  32'(evt_code),    32'h15);
    idle(6, 1);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a break prefix discards it.
    do_reset();
    send(8'hF0, 1);
    do_reset();
    step(1, 8'h1C, 0, 0);
    check("midrst_brk",   32'(evt_break),   32'd0);
    check("midrst_count", 32'(press_count), 32'd1);
    idle(2, 1);

    // 256 press/release pairs wrap the counter without overflow.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(8'(1 + (i % 127)), 1);
      send(8'hF0, 1);
      send(8'(1 + (i % 127)), 1);
    end
    idle(3, 1);
    check("wrap_count", 32'(press_count), 32'h0);
    check("wrap_ovf",   32'(overflow),    32'h0);

    // Randomized streams with varying consumer throttling and occasional resets.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit rdy;
      bit cv;
      bit rst;
      rdy = ((i / 64) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      cv  = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 299) == 0);
      step(cv, pool[$urandom_range(0, 9)], rdy, rst);
    end
    idle(8, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_event.md
Name: ps2_key_event

Overview:
- Sits directly downstream of ps2_keyboard. Consumes its raw scan-code byte stream and turns it into discrete key events.
- Strips F0 (break) and E0 (extended) prefixes and suppresses typematic repeats.
- Keeps an 8-bit count of distinct key presses and queues events in a small FIFO for the next consumer (ASCII translation, display, CPU MMIO).
- Replaces the ad-hoc "count every F0 byte" logic in the top level.

Parameters:
- FIFO_DEPTH, 4, event queue entries; power of two, minimum 2.
- CNT_W, 8, width of press_count.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous reset, active-high
- code_valid  in  1  one-cycle strobe: new byte on code_data from ps2_keyboard
- code_data  in  8  received scan-code byte
- evt_valid  out  1  FIFO non-empty; head event present
- evt_ready  in  1  consumer accepts the head event; pop when evt_valid && evt_ready
- evt_code  out  8  scan code of the head event (prefixes stripped)
- evt_break  out  1  head event is a release (1) or a press (0)
- evt_ext  out  1  head event carried an E0 prefix
- key_down  out  1  a key is currently held
- cur_code  out  8  code of the held key; 0x00 when none is held
- cur_ext  out  1  extended flag of the held key
- press_count  out  CNT_W  number of accepted press events; wraps from all-ones to 0
- overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
Reset:
- Reset is synchronous and active-high on clock. This is fixed.
- On reset: FIFO emptied (evt_valid=0), FSM to IDLE, key_down=0, cur_code=0x00, cur_ext=0, press_count=0, overflow=0.
- evt_code, evt_break, evt_ext read 0 while the FIFO is empty.
- code_valid is ignored in any cycle where reset=1.
- Reset mid-sequence (after E0 or F0) discards the partial prefix.

Prefix FSM (advances only on code_valid=1):
- IDLE:
  - byte E0 -> GOT_E0.
  - byte F0 -> GOT_F0.
  - bytes 0x00, 0xAA, 0xFA, 0xFF are discarded; stay in IDLE.
  - any other byte is a make with ext=0 -> IDLE.
- GOT_E0:
  - F0 -> GOT_E0F0.
  - E0 -> stay in GOT_E0.
  - other byte is a make with ext=1 -> IDLE.
- GOT_F0:
  - F0 -> stay in GOT_F0.
  - other byte (including E0) is a break with ext=0 -> IDLE.
- GOT_E0F0:
  - F0 -> stay in GOT_E0F0.
  - other byte is a break with ext=1 -> IDLE.

Make handling:
- If key_down=1 and {ext, code} == {cur_ext, cur_code}, the make is a typematic repeat: no event, no count change.
- Otherwise:
  - push event {code, break=0, ext};
  - press_count increments;
  - key_down=1; cur_code and cur_ext are loaded.
- press_count increments even when the push is dropped on a full FIFO.

Break handling:
- Always push event {code, break=1, ext}.
- If {ext, code} matches the held key: key_down=0, cur_code=0x00, cur_ext=0.
- If it does not match, the held-key state is unchanged.

Timing:
- Decode is registered. key_down, cur_code and press_count update on the clock edge that samples the completing byte.
- That same edge writes the FIFO, so evt_valid rises 1 cycle after the completing code_valid strobe.
- FIFO is first-word-fall-through. evt_code, evt_break and evt_ext are stable while evt_valid=1 and no pop occurs.

FIFO boundaries:
- Full with no pop in the same cycle: push is dropped, overflow is set to 1 and holds until reset.
- Full with a pop in the same cycle: both happen; no drop, occupancy unchanged.
- Empty: evt_ready is ignored; no pointer movement.
- Pointers wrap modulo FIFO_DEPTH. An extra wrap bit distinguishes full from empty.

Optional Feature:
- Macro: PS2_KEY_EVENT_EXT_EN.
- Defined: full E0 handling as above; GOT_E0 and GOT_E0F0 states exist; evt_ext and cur_ext are functional.
- Undefined:
  - GOT_E0 and GOT_E0F0 are not built.
  - E0 bytes are discarded in every state; the state does not change.
  - The following code is handled as a non-extended make or break.
  - evt_ext and cur_ext are tied to 0.

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1 -> two events, {1C,break=0,ext=0} then {1C,break=1,ext=0}. press_count=1; key_down goes 1 then 0; cur_code ends at 0x00.
- Bytes 1B, 1B, 1B, F0, 1B -> exactly one press and one release event. press_count=1; repeats produce no evt_valid.
- Bytes E0, 75, E0, F0, 75 (ext enabled) -> events {75,0,1} then {75,1,1}. With the macro undefined -> events {75,0,0} then {75,1,0}.
- evt_ready=0; send 5 distinct makes (15, 1D, 24, 2D, 2C) with FIFO_DEPTH=4 -> FIFO holds the first four, overflow=1, press_count=5. Draining yields 15, 1D, 24, 2D in order.
- Reset asserted between F0 and 1C -> after reset, the byte 1C is treated as a make: event {1C,0,0}, press_count=1.
- 256 distinct alternating make/break pairs -> press_count wraps to 0x00, with no overflow when evt_ready=1.
